// File: rtl/inst_pkg.sv
// Shared definitions for the instruction fetch unit and the decode stage it feeds.
package inst_pkg;
  localparam int A_DEF  = 10;
  localparam int W_DEF  = 9;
  localparam int OW_DEF = 6;
  localparam int CW_DEF = 16;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fetch_state_t;

  // Opcodes live in the top three bits of each 9-bit instruction word.
  localparam logic [2:0] OP_ALU  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_STOR = 3'b010;
  localparam logic [2:0] OP_BR   = 3'b011;
  localparam logic [2:0] OP_JMP  = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b111;
endpackage

// File: rtl/pc_next.sv
// Next-PC candidates: the sequential successor, and the redirect target where a jump beats a relative branch.
module pc_next #(
  parameter int A  = 10,
  parameter int OW = 6
) (
  input  logic [A-1:0]         i_pc,
  input  logic [A-1:0]         i_inst_pc,
  input  logic signed [OW-1:0] i_offset,
  input  logic                 i_jump,
  input  logic [A-1:0]         i_target,
  output logic [A-1:0]         o_seq_pc,
  output logic [A-1:0]         o_redir_pc
);
  logic signed [A-1:0] w_off_ext;
  logic [A-1:0]        w_branch_pc;

  // Branches are relative to the instruction being decoded, not the PC; the sum wraps mod 2**A.
  assign w_off_ext   = A'(i_offset);
  assign w_branch_pc = i_inst_pc + $unsigned(w_off_ext);
  assign o_seq_pc    = i_pc + A'(1);
  assign o_redir_pc  = i_jump ? i_target : w_branch_pc;
endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: drives the ROM address from the PC and registers the returned word with its PC for decode.
module inst_fetch
  import inst_pkg::*;
#(
  parameter int A  = A_DEF,
  parameter int W  = W_DEF,
  parameter int OW = OW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 Start,
  output logic [A-1:0]         InstAddress,
  input  logic [W-1:0]         InstIn,
  input  logic                 Stall,
  input  logic                 BranchEn,
  input  logic signed [OW-1:0] Offset,
  input  logic                 JumpEn,
  input  logic [A-1:0]         Target,
  input  logic                 Halt,
  output logic [W-1:0]         Inst,
  output logic [A-1:0]         InstPC,
  output logic                 InstValid,
  output logic                 Done,
  output logic [CW-1:0]        CycleCount
);
  fetch_state_t  r_state, w_state_nxt;
  logic [A-1:0]  r_pc, w_pc_nxt;
  logic [A-1:0]  r_inst_pc, w_inst_pc_nxt;
  logic [W-1:0]  r_inst, w_inst_nxt;
  logic          r_valid, w_valid_nxt;
  logic          r_done, w_done_nxt;
  logic [CW-1:0] r_cyc, w_cyc_nxt;
  logic [A-1:0]  w_seq_pc, w_redir_pc;

  pc_next #(.A(A), .OW(OW)) u_pc_next (
    .i_pc       (r_pc),
    .i_inst_pc  (r_inst_pc),
    .i_offset   (Offset),
    .i_jump     (JumpEn),
    .i_target   (Target),
    .o_seq_pc   (w_seq_pc),
    .o_redir_pc (w_redir_pc)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_inst_pc_nxt = r_inst_pc;
    w_inst_nxt    = r_inst;
    w_valid_nxt   = r_valid;
    w_done_nxt    = r_done;
    w_cyc_nxt     = r_cyc;
    case (r_state)
      IDLE: begin
        w_pc_nxt    = '0;
        w_valid_nxt = 1'b0;
        if (Start) begin
          w_state_nxt = RUN;
          w_cyc_nxt   = '0;
        end
      end
      RUN: begin
        w_cyc_nxt = (r_cyc == '1) ? r_cyc : r_cyc + CW'(1);
        // Control inputs describe the word in Inst, so they only count while it is live.
        if (r_valid && Halt) begin
          w_state_nxt = DONE;
          w_valid_nxt = 1'b0;
          w_done_nxt  = 1'b1;
        end else if (r_valid && (JumpEn || BranchEn)) begin
          w_pc_nxt    = w_redir_pc;
          w_valid_nxt = 1'b0;
        end else if (!Stall) begin
          w_inst_nxt    = InstIn;
          w_inst_pc_nxt = r_pc;
          w_valid_nxt   = 1'b1;
          w_pc_nxt      = w_seq_pc;
        end
      end
      DONE: begin
        w_valid_nxt = 1'b0;
        w_done_nxt  = 1'b1;
        if (Start) begin
          w_state_nxt = RUN;
          w_pc_nxt    = '0;
          w_cyc_nxt   = '0;
          w_done_nxt  = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state   <= IDLE;
      r_pc      <= '0;
      r_inst_pc <= '0;
      r_inst    <= '0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_cyc     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_inst_pc <= w_inst_pc_nxt;
      r_inst    <= w_inst_nxt;
      r_valid   <= w_valid_nxt;
      r_done    <= w_done_nxt;
      r_cyc     <= w_cyc_nxt;
    end
  end

  assign InstAddress = r_pc;
  assign Inst        = r_inst;
  assign InstPC      = r_inst_pc;
  assign InstValid   = r_valid;
  assign Done        = r_done;
  assign CycleCount  = r_cyc;
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: vector table plus hand-written wrap and mid-run reset sequences.
module tb_inst_fetch;
  logic              Clk = 1'b0;
  logic              Reset_n;
  logic              Start;
  logic [9:0]        InstAddress;
  logic [8:0]        InstIn;
  logic              Stall;
  logic              BranchEn;
  logic signed [5:0] Offset;
  logic              JumpEn;
  logic [9:0]        Target;
  logic              Halt;
  logic [8:0]        Inst;
  logic [9:0]        InstPC;
  logic              InstValid;
  logic              Done;
  logic [15:0]       CycleCount;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       start, stall, br;
    logic [5:0] off;
    logic       jmp;
    logic [9:0] tgt;
    logic       halt;
    logic [9:0] e_addr;
    logic [8:0] e_inst;
    logic [9:0] e_ipc;
    logic       e_v, e_d;
    logic [15:0] e_cyc;
  } vec_t;

  vec_t vq[$];

  inst_fetch dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .InstAddress(InstAddress),
    .InstIn(InstIn), .Stall(Stall), .BranchEn(BranchEn), .Offset(Offset),
    .JumpEn(JumpEn), .Target(Target), .Halt(Halt), .Inst(Inst), .InstPC(InstPC),
    .InstValid(InstValid), .Done(Done), .CycleCount(CycleCount)
  );

  // ROM returns its own address (truncated to the word width).
  assign InstIn = InstAddress[8:0];

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic row(input logic start, stall, br, input logic [5:0] off, input logic jmp,
                     input logic [9:0] tgt, input logic halt, input logic [9:0] e_addr,
                     input logic [8:0] e_inst, input logic [9:0] e_ipc, input logic e_v, e_d,
                     input logic [15:0] e_cyc);
    vec_t v;
    v.start = start; v.stall = stall; v.br = br; v.off = off; v.jmp = jmp; v.tgt = tgt;
    v.halt = halt; v.e_addr = e_addr; v.e_inst = e_inst; v.e_ipc = e_ipc;
    v.e_v = e_v; v.e_d = e_d; v.e_cyc = e_cyc;
    vq.push_back(v);
  endtask

  task automatic chk_all(input string tag, input int idx, input logic [9:0] a, input logic [8:0] i,
                         input logic [9:0] p, input logic v, input logic d, input logic [15:0] c);
    chk({tag, "_addr"}, idx, 32'(InstAddress), 32'(a));
    chk({tag, "_inst"}, idx, 32'(Inst), 32'(i));
    chk({tag, "_ipc"}, idx, 32'(InstPC), 32'(p));
    chk({tag, "_valid"}, idx, 32'(InstValid), 32'(v));
    chk({tag, "_done"}, idx, 32'(Done), 32'(d));
    chk({tag, "_cyc"}, idx, 32'(CycleCount), 32'(c));
  endtask

  task automatic clear_inputs();
    Start = 0; Stall = 0; BranchEn = 0; Offset = '0; JumpEn = 0; Target = '0; Halt = 0;
  endtask

  initial begin
    //   st sl br off    jp tgt     ht | addr    inst    ipc     v d cyc
    row(1, 0, 0, 6'h00, 0, 10'h000, 0, 10'h000, 9'h000, 10'h000, 0, 0, 0);
    row(0, 0, 0, 6'h00, 0, 10'h000, 0, 10'h001, 9'h000, 10'h000, 1, 0, 1);
    row(0, 0, 0, 6'h00, 0, 10'h000, 0, 10'h002, 9'h001, 10'h001, 1, 0, 2);
    row(0, 0, 0, 6'h00, 0, 10'h000, 0, 10'h003, 9'h002, 10'h002, 1, 0, 3);
    row(0, 0, 0, 6'h00, 0, 10'h000, 0, 10'h004, 9'h003, 10'h003, 1, 0, 4);
    row(0, 0, 0, 6'h00, 0, 10'h000, 0, 10'h005, 9'h004, 10'h004, 1, 0, 5);
    row(0, 0, 0, 6'h00, 0, 10'h000, 0, 10'h006, 9'h005, 10'h005, 1, 0, 6);
    // branch -3 from InstPC 5 beats a concurrent stall
    row(0, 1, 1, 6'h3D, 0, 10'h000, 0, 10'h002, 9'h005, 10'h005, 0, 0, 7);
    // branch held during the bubble is ignored
    row(0, 0, 1, 6'h3D, 0, 10'h000, 0, 10'h003, 9'h002, 10'h002, 1, 0, 8);
    row(0, 0, 0, 6'h00, 0, 10'h000, 0, 10'h004, 9'h003, 10'h003, 1, 0, 9);
    row(0, 0, 0, 6'h00, 0, 10'h000, 0, 10'h005, 9'h004, 10'h004, 1, 0, 10);
    row(0, 0, 0, 6'h00, 0, 10'h000, 0, 10'h006, 9'h005, 10'h005, 1, 0, 11);
    row(0, 0, 0, 6'h00, 0, 10'h000, 0, 10'h007, 9'h006, 10'h006, 1, 0, 12);
    row(0, 0, 0, 6'h00, 0, 10'h000, 1, 10'h007, 9'h006, 10'h006, 0, 1, 13);
    row(0, 1, 1, 6'h04, 0, 10'h000, 1, 10'h007, 9'h006, 10'h006, 0, 1, 13);
    row(1, 0, 0, 6'h00, 0, 10'h000, 0, 10'h000, 9'h006, 10'h006, 0, 0, 0);
    // halt/jump with InstValid=0 are ignored
    row(0, 0, 0, 6'h00, 1, 10'h100, 1, 10'h001, 9'h000, 10'h000, 1, 0, 1);
    row(0, 0, 0, 6'h00, 0, 10'h000, 0, 10'h002, 9'h001, 10'h001, 1, 0, 2);
    row(0, 0, 0, 6'h00, 0, 10'h000, 0, 10'h003, 9'h002, 10'h002, 1, 0, 3);
    row(0, 0, 0, 6'h00, 0, 10'h000, 0, 10'h004, 9'h003, 10'h003, 1, 0, 4);
    row(0, 0, 0, 6'h00, 0, 10'h000, 0, 10'h005, 9'h004, 10'h004, 1, 0, 5);
    row(0, 0, 0, 6'h00, 0, 10'h000, 0, 10'h006, 9'h005, 10'h005, 1, 0, 6);
    row(0, 0, 0, 6'h00, 0, 10'h000, 0, 10'h007, 9'h006, 10'h006, 1, 0, 7);
    row(0, 0, 0, 6'h00, 0, 10'h000, 0, 10'h008, 9'h007, 10'h007, 1, 0, 8);
    row(0, 1, 0, 6'h00, 0, 10'h000, 0, 10'h008, 9'h007, 10'h007, 1, 0, 9);
    row(0, 1, 0, 6'h00, 0, 10'h000, 0, 10'h008, 9'h007, 10'h007, 1, 0, 10);
    row(0, 1, 0, 6'h00, 0, 10'h000, 0, 10'h008, 9'h007, 10'h007, 1, 0, 11);
    row(0, 0, 0, 6'h00, 0, 10'h000, 0, 10'h009, 9'h008, 10'h008, 1, 0, 12);
    // Start ignored in RUN
    row(1, 0, 0, 6'h00, 0, 10'h000, 0, 10'h00A, 9'h009, 10'h009, 1, 0, 13);
    // halt beats jump
    row(0, 0, 0, 6'h00, 1, 10'h100, 1, 10'h00A, 9'h009, 10'h009, 0, 1, 14);
    row(1, 0, 0, 6'h00, 0, 10'h000, 0, 10'h000, 9'h009, 10'h009, 0, 0, 0);
    row(0, 0, 0, 6'h00, 0, 10'h000, 0, 10'h001, 9'h000, 10'h000, 1, 0, 1);
    // jump beats branch
    row(0, 0, 1, 6'h04, 1, 10'h3F0, 0, 10'h3F0, 9'h000, 10'h000, 0, 0, 2);
    row(0, 0, 0, 6'h00, 0, 10'h000, 0, 10'h3F1, 9'h1F0, 10'h3F0, 1, 0, 3);

    clear_inputs();
    Reset_n = 0;
    repeat (2) @(posedge Clk);
    #1;
    chk_all("reset", 0, 10'h0, 9'h0, 10'h0, 0, 0, 16'h0);
    Reset_n = 1;

    for (int k = 0; k < vq.size(); k++) begin
      Start = vq[k].start; Stall = vq[k].stall; BranchEn = vq[k].br; Offset = vq[k].off;
      JumpEn = vq[k].jmp; Target = vq[k].tgt; Halt = vq[k].halt;
      @(posedge Clk);
      #1;
      chk_all("vec", k, vq[k].e_addr, vq[k].e_inst, vq[k].e_ipc, vq[k].e_v, vq[k].e_d, vq[k].e_cyc);
    end
    clear_inputs();

    // Run on from 0x3F1 through the top of the address space.
    for (int k = 1; k <= 16; k++) begin
      logic [9:0] e_pc, e_ipc;
      e_pc  = 10'(10'h3F1 + k);
      e_ipc = 10'(10'h3F0 + k);
      @(posedge Clk);
      #1;
      chk("wrap_addr", k, 32'(InstAddress), 32'(e_pc));
      chk("wrap_ipc", k, 32'(InstPC), 32'(e_ipc));
      chk("wrap_inst", k, 32'(Inst), 32'(e_ipc[8:0]));
    end

    repeat (19) @(posedge Clk);
    #1;
    chk("midrun_addr", 0, 32'(InstAddress), 32'd20);
    Reset_n = 0;
    @(posedge Clk);
    #1;
    chk_all("midrun_rst", 0, 10'h0, 9'h0, 10'h0, 0, 0, 16'h0);
    Reset_n = 1;
    for (int k = 0; k < 3; k++) begin
      @(posedge Clk);
      #1;
      chk("idle_addr", k, 32'(InstAddress), 32'd0);
      chk("idle_valid", k, 32'(InstValid), 32'd0);
      chk("idle_cyc", k, 32'(CycleCount), 32'd0);
    end
    Start = 1;
    @(posedge Clk);
    #1;
    Start = 0;
    @(posedge Clk);
    #1;
    chk_all("restart", 0, 10'h1, 9'h0, 10'h0, 1, 0, 16'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction fetch unit: the requesting end of the instruction-memory interface. It drives InstAddress to the combinational instruction ROM and captures the returned word.
- Holds the program counter and registers the fetched instruction, with its PC, for decode.
- Handles sequential fetch, relative branch, absolute jump, stall and halt.
- Sits between the instruction ROM and decode/control. Also reports Done and a run-cycle count to the test bench.

Parameters:
- A, 10, instruction address width (ROM depth 2**A).
- W, 9, instruction width.
- OW, 6, branch offset width (signed two's complement).
- CW, 16, cycle-counter width.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Reset_n  in  1  synchronous active-low reset.
- Start  in  1  one-cycle pulse; begins a run from address 0.
- InstAddress  out  A  address to instruction ROM; equals PC.
- InstIn  in  W  ROM data, combinational from InstAddress.
- Stall  in  1  decode cannot accept; hold fetch state.
- BranchEn  in  1  taken relative branch for the instruction in Inst.
- Offset  in  OW  signed branch offset.
- JumpEn  in  1  absolute jump for the instruction in Inst.
- Target  in  A  jump target.
- Halt  in  1  instruction in Inst is a halt.
- Inst  out  W  registered instruction.
- InstPC  out  A  address Inst was fetched from.
- InstValid  out  1  Inst holds a live instruction.
- Done  out  1  program halted.
- CycleCount  out  CW  cycles spent in RUN.

Behaviour:
- Reset (Reset_n=0 at a rising edge): state=IDLE, PC=0, Inst=0, InstPC=0, InstValid=0, Done=0, CycleCount=0. Reset overrides every other input, including mid-run.
- States: IDLE, RUN, DONE.
- IDLE:
  - PC holds at 0; InstValid=0.
  - Start=1 -> RUN, PC=0, CycleCount=0.
- RUN, every cycle:
  - CycleCount += 1, saturating at 2**CW-1.
  - Events are evaluated with priority Halt > redirect (JumpEn or BranchEn) > Stall > sequential.
  - Halt, and only when InstValid=1 -> DONE, InstValid<=0, Done<=1, PC holds.
  - JumpEn (InstValid=1) -> PC<=Target, InstValid<=0, Inst holds.
  - BranchEn (InstValid=1) -> PC<=InstPC + sext(Offset) mod 2**A, InstValid<=0, Inst holds.
    - The redirect squashes the word fetched in this cycle, i.e. a 1-cycle bubble.
    - JumpEn beats BranchEn if both are asserted.
  - Stall -> PC, Inst, InstPC and InstValid all hold.
  - Otherwise -> Inst<=InstIn, InstPC<=PC, InstValid<=1, PC<=PC+1 mod 2**A.
    - The PC wraps from 2**A-1 to 0.
  - Halt, JumpEn and BranchEn are ignored while InstValid=0.
  - Start is ignored in RUN.
- DONE:
  - Done=1; PC, Inst and CycleCount are frozen; InstValid=0.
  - Start=1 -> RUN with PC=0, CycleCount=0, Done<=0.
- Latency: the word at address X appears on Inst one cycle after InstAddress=X, absent stall.
- Throughput: one instruction per cycle with no stalls or redirects.
- Arithmetic: Offset is sign-extended to A bits and the sum truncated to A bits. Unsigned wrap is intended, not an error.
- InstAddress is a direct combinational copy of the PC register.

Decomposition:
- Shared package inst_pkg holds:
  - typedef fetch_state_t {IDLE, RUN, DONE};
  - localparams for the default A/W/OW;
  - the opcode constants used by decode.
- No sub-module is required.
- Optional small sub-module pc_next computes the next PC: priority mux plus adder.

Test Plan:
- Reset then Start with ROM word = address:
  - InstAddress steps 0,1,2,3…;
  - Inst lags one cycle (Inst=0 at InstPC=0, then 1…);
  - InstValid=1 from the cycle after Start+1.
- BranchEn with Offset=-3 while InstPC=5 -> next InstAddress=2; InstValid=0 for one cycle; the next Inst is from address 2.
- Simultaneous JumpEn (Target=0x3F0) and BranchEn (Offset=+4) -> PC=0x3F0. Running on from 0x3FF -> InstAddress wraps to 0.
- Stall held 3 cycles at InstPC=7 -> Inst, InstPC=7 and InstAddress frozen for 3 cycles, then resume at 9.
- Halt at CycleCount=12:
  - Done=1 and InstValid=0 next cycle;
  - CycleCount frozen at 13;
  - a later Start restarts from 0 with Done=0.
- Reset_n=0 mid-run at PC=20 -> all outputs zero next edge, state IDLE; Start is required to resume.
